// File: rtl/y86_arb_pkg.sv
// Shared types and constants for the Y86 two-port memory bus arbiter.
package y86_arb_pkg;

  localparam int unsigned ID_W     = 1;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // One latched bus transaction.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } arb_txn_t;

  // Wait-state count as loaded into the access down-counter, clamped to its range.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned ws);
    return (ws > WAIT_MAX) ? CNT_W'(WAIT_MAX) : CNT_W'(ws);
  endfunction

endpackage

// File: rtl/y86_rr_pick2.sv
// Stateless two-way round-robin pick: a lone requester wins, on contention
// the port that was not granted last time wins.
module y86_rr_pick2
  import y86_arb_pkg::*;
(
  input  logic            valid0,
  input  logic            valid1,
  input  logic [ID_W-1:0] last,
  output logic            grant_any,
  output logic [ID_W-1:0] grant_id
);

  // Combinational selection from current requests and previous winner.
  always_comb begin
    grant_any = valid0 | valid1;
    grant_id  = ID_W'(0);
    if (valid0 && valid1) begin
      grant_id = ~last;
    end else if (valid1) begin
      grant_id = ID_W'(1);
    end
  end

endmodule

// File: rtl/y86_bus_arbiter.sv
// Y86 two-requester memory bus arbiter: IDLE -> ACCESS -> RESP -> IDLE,
// round-robin grant, WAIT_STATES extra access cycles, one-cycle ready pulse.
// Optional per-port grant counters are built when Y86_ARB_STATS_EN is defined.
module y86_bus_arbiter
  import y86_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] req0_rdata,
  output logic [31:0] req1_rdata,
  output logic [31:0] bus_A,
  output logic [31:0] bus_out,
  output logic        bus_WE,
  output logic        bus_RE,
  input  logic [31:0] bus_in,
  output logic        busy,
  output logic        last_grant
`ifdef Y86_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_take;
  logic              w_finish;

  logic              w_grant_any;
  logic [ID_W-1:0]   w_grant_id;
  arb_txn_t          w_req;

  arb_txn_t          r_txn;
  logic [ID_W-1:0]   r_last;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready0;
  logic              r_ready1;
  logic [ADDR_W-1:0] r_bus_a;
  logic [DATA_W-1:0] r_bus_out;
  logic              r_bus_we;
  logic              r_bus_re;
  logic              r_busy;

  // Round-robin winner among the current requests.
  y86_rr_pick2 u_pick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (r_last),
    .grant_any (w_grant_any),
    .grant_id  (w_grant_id)
  );

  // Fields of the winning requester, ready to be latched at grant.
  always_comb begin
    w_req    = '0;
    w_req.id = w_grant_id;
    if (w_grant_id == ID_W'(1)) begin
      w_req.we    = req1_we;
      w_req.addr  = req1_addr;
      w_req.wdata = req1_wdata;
    end else begin
      w_req.we    = req0_we;
      w_req.addr  = req0_addr;
      w_req.wdata = req0_wdata;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, wait counter and grant/finish strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = wait_load(WAIT_STATES);
          w_take      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_finish    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Latched transaction, bus drive, read capture and ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn     <= '0;
      r_last    <= ID_W'(1);
      r_rdata   <= '0;
      r_ready0  <= 1'b0;
      r_ready1  <= 1'b0;
      r_bus_a   <= '0;
      r_bus_out <= '0;
      r_bus_we  <= 1'b0;
      r_bus_re  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_take) begin
        r_txn     <= w_req;
        r_last    <= w_grant_id;
        r_bus_a   <= w_req.addr;
        r_bus_out <= w_req.wdata;
        r_bus_we  <= w_req.we;
        r_bus_re  <= ~w_req.we;
      end else if (w_finish) begin
        r_bus_a   <= '0;
        r_bus_out <= '0;
        r_bus_we  <= 1'b0;
        r_bus_re  <= 1'b0;
        if (!r_txn.we) begin
          r_rdata <= bus_in;
        end
        r_ready0 <= (r_txn.id == ID_W'(0));
        r_ready1 <= (r_txn.id == ID_W'(1));
      end
    end
  end

  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign req0_rdata = r_rdata;
  assign req1_rdata = r_rdata;
  assign bus_A      = r_bus_a;
  assign bus_out    = r_bus_out;
  assign bus_WE     = r_bus_we;
  assign bus_RE     = r_bus_re;
  assign busy       = r_busy;
  assign last_grant = r_last;

`ifdef Y86_ARB_STATS_EN
  logic [STAT_W-1:0] r_gcnt0;
  logic [STAT_W-1:0] r_gcnt1;

  // Per-port grant counters, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else if (w_take) begin
      if (w_grant_id == ID_W'(1)) begin
        r_gcnt1 <= r_gcnt1 + STAT_W'(1);
      end else begin
        r_gcnt0 <= r_gcnt0 + STAT_W'(1);
      end
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench for y86_bus_arbiter (WAIT_STATES=1 main instance, WAIT_STATES=0 second instance).
module tb_y86_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata, bus_in;

  logic        req0_ready, req1_ready, bus_WE, bus_RE, busy, last_grant;
  logic [31:0] req0_rdata, req1_rdata, bus_A, bus_out;

  logic        z_req0_ready, z_req1_ready, z_bus_WE, z_bus_RE, z_busy, z_last_grant;
  logic [31:0] z_req0_rdata, z_req1_rdata, z_bus_A, z_bus_out;

`ifdef Y86_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, z_grant_cnt0, z_grant_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  y86_bus_arbiter #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
    .bus_A(bus_A), .bus_out(bus_out), .bus_WE(bus_WE), .bus_RE(bus_RE), .bus_in(bus_in),
    .busy(busy), .last_grant(last_grant)
`ifdef Y86_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  y86_bus_arbiter #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(z_req0_ready), .req1_ready(z_req1_ready),
    .req0_rdata(z_req0_rdata), .req1_rdata(z_req1_rdata),
    .bus_A(z_bus_A), .bus_out(z_bus_out), .bus_WE(z_bus_WE), .bus_RE(z_bus_RE), .bus_in(bus_in),
    .busy(z_busy), .last_grant(z_last_grant)
`ifdef Y86_ARB_STATS_EN
    , .grant_cnt0(z_grant_cnt0), .grant_cnt1(z_grant_cnt1)
`endif
  );

  typedef struct {
    logic        v0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic        we1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] bin;
    logic        exp_id;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drop_all();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Apply one vector starting from IDLE at posedge+1; returns to IDLE at posedge+1.
  task automatic run_vec(input vec_t v);
    int          strobes;
    int          ready_cyc;
    logic [31:0] ea, ed;
    logic        ew;
    strobes   = 0;
    ready_cyc = 0;
    ea = v.exp_id ? v.a1 : v.a0;
    ed = v.exp_id ? v.d1 : v.d0;
    ew = v.exp_id ? v.we1 : v.we0;
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
    bus_in = v.bin;
    for (int k = 1; k <= 12 && ready_cyc == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus_RE || bus_WE) begin
        strobes++;
        chk("vec_bus_A", bus_A, ea);
        chk("vec_bus_out", bus_out, ed);
        chk("vec_bus_WE", 32'(bus_WE), 32'(ew));
        chk("vec_bus_RE", 32'(bus_RE), 32'(!ew));
      end
      if (req0_ready || req1_ready) begin
        ready_cyc = k;
        chk("vec_ready0", 32'(req0_ready), 32'(!v.exp_id));
        chk("vec_ready1", 32'(req1_ready), 32'(v.exp_id));
        chk("vec_rdata0", req0_rdata, v.exp_rdata);
        chk("vec_rdata1", req1_rdata, v.exp_rdata);
        chk("vec_last_grant", 32'(last_grant), 32'(v.exp_id));
      end
    end
    chk("vec_latency", 32'(ready_cyc), 32'd3);
    chk("vec_strobe_cycles", 32'(strobes), 32'd2);
    drop_all();
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("idle_strobes", 32'({bus_WE, bus_RE}), 32'd0);
    chk("idle_bus_A", bus_A, 32'd0);
  endtask

  initial begin
    int nready;
    int both_ready;
    int wait_cyc;
    logic exp_g;

    // v0 req0 read, v1 req1 write, then contention and lone-requester cases.
    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,    1'b0, 1'b0, 32'h0,  32'h0,    32'hCAFEBABE, 1'b0, 32'hCAFEBABE};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'h20, 32'h1234, 32'hDEADDEAD, 1'b1, 32'hCAFEBABE};
    vecs[2] = '{1'b1, 1'b0, 32'h30, 32'h77,   1'b1, 1'b0, 32'h40, 32'h88,   32'h11112222, 1'b0, 32'h11112222};
    vecs[3] = '{1'b1, 1'b1, 32'h50, 32'hAA,   1'b1, 1'b0, 32'h60, 32'h99,   32'h33334444, 1'b1, 32'h33334444};
    vecs[4] = '{1'b1, 1'b1, 32'h70, 32'hBEEF, 1'b1, 1'b1, 32'h80, 32'hF00D, 32'h12121212, 1'b0, 32'h33334444};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h90, 32'h5,    32'h5555AAAA, 1'b1, 32'h5555AAAA};
    vecs[6] = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'hA0, 32'h6,    32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F};

    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    bus_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_rdata1", req1_rdata, 32'd0);
    chk("rst_bus_A", bus_A, 32'd0);
    chk("rst_bus_out", bus_out, 32'd0);
    chk("rst_strobes", 32'({bus_WE, bus_RE}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

`ifdef Y86_ARB_STATS_EN
    chk("stats_cnt0", 32'(grant_cnt0), 32'd3);
    chk("stats_cnt1", 32'(grant_cnt1), 32'd4);
`endif

    // WAIT_STATES=0 instance: single read, one ACCESS cycle, ready on cycle 2.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h44; bus_in = 32'h600DF00D;
    @(posedge clk);
    #1;
    chk("ws0_c1_bus_RE", 32'(z_bus_RE), 32'd1);
    chk("ws0_c1_bus_A", z_bus_A, 32'h44);
    chk("ws0_c1_ready", 32'(z_req0_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ws0_c2_ready", 32'(z_req0_ready), 32'd1);
    chk("ws0_c2_rdata", z_req0_rdata, 32'h600DF00D);
    chk("ws0_c2_bus_RE", 32'(z_bus_RE), 32'd0);
    drop_all();

    // Saturation from reset: both valid held, grants alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h200;
    bus_in = 32'hA5A5A5A5;
    nready = 0;
    both_ready = 0;
    for (int k = 0; k < 40 && nready < 4; k++) begin
      @(posedge clk);
      #1;
      if (req0_ready && req1_ready) both_ready++;
      if (req0_ready || req1_ready) begin
        exp_g = (nready % 2) == 1;
        chk("sat_ready1", 32'(req1_ready), 32'(exp_g));
        chk("sat_last_grant", 32'(last_grant), 32'(exp_g));
        nready++;
      end
    end
    chk("sat_nready", 32'(nready), 32'd4);
    chk("sat_both_ready", 32'(both_ready), 32'd0);
    drop_all();

    // Reset in the middle of an access aborts it.
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h300; bus_in = 32'h1;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_last_grant", 32'(last_grant), 32'd0);
    chk("mid_bus_RE", 32'(bus_RE), 32'd1);
    rst = 1'b1;
    req0_valid = 1'b0;
    #1;
    chk("mid_rst_bus_RE", 32'(bus_RE), 32'd0);
    chk("mid_rst_bus_A", bus_A, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last_grant", 32'(last_grant), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 32'h400;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h500;
    @(posedge clk);
    #1;
    chk("post_rst_grant", 32'(last_grant), 32'd0);
    chk("post_rst_bus_A", bus_A, 32'h400);
    wait_cyc = 0;
    while (!req0_ready && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    drop_all();
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_bus_arbiter.md
Y86_BUS_ARBITER -- requirements
Module: y86_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1 (range 0..15), meaning extra memory cycles per access beyond the first.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  access request from requester 0/1.
REQ-005 SHALL have ports req0_we/req1_we  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports req0_addr/req1_addr, req0_wdata/req1_wdata  input  32 each  address and write data.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have ports req0_rdata/req1_rdata  output  32 each  read data, valid while the matching ready is high.
REQ-009 SHALL have ports bus_A  output  32, bus_out  output  32, bus_WE  output  1, bus_RE  output  1, bus_in  input  32  shared memory bus.
REQ-010 SHALL have ports busy  output  1 (state != IDLE) and last_grant  output  1 (id of most recent grant).

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-012 IDLE: if any valid is high, SHALL grant, latch id/we/addr/wdata into internal registers, go to ACCESS; otherwise stay in IDLE.
REQ-013 SHALL arbitrate round-robin: one valid -> grant it; both valid -> grant the id != last_grant; last_grant updates on every grant.
REQ-014 ACCESS SHALL last exactly WAIT_STATES+1 cycles, tracked by a 4-bit down-counter loaded at grant.
REQ-015 During ACCESS, bus_A = latched addr, bus_out = latched wdata, bus_WE = latched we, bus_RE = !latched we, all held constant.
REQ-016 Outside ACCESS, bus_A = 0, bus_out = 0, bus_WE = 0, bus_RE = 0.
REQ-017 On the last ACCESS cycle of a read, SHALL register bus_in into the rdata register; writes leave rdata unchanged.
REQ-018 RESP: granted reqN_ready = 1 for exactly one cycle, other ready = 0; both reqN_rdata outputs drive the rdata register.
REQ-019 Latency: ready SHALL rise WAIT_STATES+2 cycles after the IDLE edge that sampled valid; no new grant is made in RESP.
REQ-020 Requesters hold valid and fields stable until ready; deasserting valid or changing fields during ACCESS/RESP SHALL be ignored and the latched transaction SHALL complete.
REQ-021 A valid still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-022 Back-to-back saturation (both valid continuously) SHALL alternate grants 0,1,0,1,...

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, counter 0, last_grant = 1 (so port 0 wins first contention), rdata = 0, latched registers 0.
REQ-024 During and after reset all outputs SHALL be 0 except last_grant = 1; reset mid-ACCESS SHALL abort the access with bus strobes dropping asynchronously and no ready pulse.

Configuration
REQ-025 Macro Y86_ARB_STATS_EN, when defined, SHALL add outputs grant_cnt0 and grant_cnt1 (output 16 each), incremented on each grant to that port, wrapping 0xFFFF -> 0, reset to 0.
REQ-026 Without Y86_ARB_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared package y86_arb_pkg SHALL hold the FSM state typedef (IDLE, ACCESS, RESP), the ID width constant, and the WAIT_STATES maximum (15).
REQ-028 Round-robin selection SHALL be a sub-module y86_rr_pick2 (inputs valid0, valid1, last; outputs grant_any, grant_id), with no state.

Verification
REQ-029 WAIT_STATES=1, req0 read addr 0x10, bus_in=0xCAFEBABE -> bus_RE high 2 cycles with bus_A=0x10; req0_ready pulses on cycle 3; req0_rdata=0xCAFEBABE.
REQ-030 req1 write addr 0x20, data 0x1234 -> bus_WE high 2 cycles, bus_out=0x1234; req1_ready pulses once; bus_RE stays 0.
REQ-031 Both valid from reset, held -> grant order 0,1,0,1; last_grant toggles; no cycle with both readys high.
REQ-032 WAIT_STATES=0, single read -> ACCESS 1 cycle; ready at cycle 2 after sampling.
REQ-033 rst asserted mid-ACCESS -> bus strobes 0 in the same cycle, no ready pulse, last_grant=1; next contention grants port 0.
REQ-034 With Y86_ARB_STATS_EN: 3 grants to port 0, 2 to port 1 -> grant_cnt0=3, grant_cnt1=2; counter preloaded to 0xFFFF wraps to 0 on the next grant.
